gp_reg_bank: RTL

GP_REG_BANK -- requirements
Module: gp_reg_bank

---
 rtl/gp_reg_bank.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gp_reg_bank.sv
// General-purpose register bank: 12 RW regs, status/counter/ID read-only regs, handshake FSMs.
// Define GP_REG_BANK_IRQ_EN to turn reg 15 into W1C sticky interrupt status driving irq.
module gp_reg_bank #(
   parameter int unsigned GP_ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter logic [31:0] ID_VALUE      = 32'h6B5E0001
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      write,
   input  logic [GP_ADDR_WIDTH-1:0]  write_addrs,
   input  logic [DATA_WIDTH-1:0]     write_data,
   input  logic [DATA_WIDTH/8-1:0]   write_strobe,
   output logic                      write_done,
   output logic                      write_error,
   input  logic                      read,
   input  logic [GP_ADDR_WIDTH-1:0]  read_addrs,
   output logic [DATA_WIDTH-1:0]     read_data,
   output logic                      read_done,
   output logic                      read_error,
   input  logic [31:0]               status_in,
   output logic [31:0]               ctrl0,
   input  logic [7:0]                irq_src,
   output logic                      irq
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   typedef enum logic [1:0] {StIdle, StAck, StWaitLow} st_t;

   st_t                   r_wst, r_rst;
   logic [DATA_WIDTH-1:0] r_regs [12];
   logic [31:0]           r_cnt;
   logic                  r_write_done, r_write_error, r_read_done, r_read_error;
   logic [DATA_WIDTH-1:0] r_read_data;

   logic [3:0]            w_widx, w_ridx;
   logic                  w_werr, w_rerr, w_wupd;
   logic [DATA_WIDTH-1:0] w_wmask, w_rmux, w_reg15;

   assign w_widx = write_addrs[5:2];
   assign w_ridx = read_addrs[5:2];
   assign w_werr = (write_addrs[1:0] != 2'b00) || (w_widx inside {4'd12, 4'd13, 4'd14});
   assign w_rerr = (read_addrs[1:0] != 2'b00);
   assign w_wupd = (r_wst == StIdle) && write && !w_werr;

   always_comb begin
      w_wmask = '0;
      for (int i = 0; i < NB; i++) w_wmask[8*i +: 8] = {8{write_strobe[i]}};
   end

   always_comb begin
      w_rmux = '0;
      case (w_ridx)
         4'd12:   w_rmux = DATA_WIDTH'(status_in);
         4'd13:   w_rmux = DATA_WIDTH'(r_cnt);
         4'd14:   w_rmux = DATA_WIDTH'(ID_VALUE);
         4'd15:   w_rmux = w_reg15;
         default: begin
            for (int i = 0; i < 12; i++) if (w_ridx == 4'(i)) w_rmux = r_regs[i];
         end
      endcase
   end

   // Register update happens on the accept edge, so a same-edge read sees the old value.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wst         <= StIdle;
         r_write_done  <= 1'b0;
         r_write_error <= 1'b0;
         for (int i = 0; i < 12; i++) r_regs[i] <= '0;
      end else begin
         r_write_done  <= 1'b0;
         r_write_error <= 1'b0;
         unique case (r_wst)
            StIdle: if (write) begin
               r_wst         <= StAck;
               r_write_done  <= 1'b1;
               r_write_error <= w_werr;
            end
            StAck:     r_wst <= StWaitLow;
            StWaitLow: if (!write) r_wst <= StIdle;
            default:   r_wst <= StIdle;
         endcase
         for (int i = 0; i < 12; i++) begin
            if (w_wupd && w_widx == 4'(i)) begin
               r_regs[i] <= (r_regs[i] & ~w_wmask) | (write_data & w_wmask);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rst        <= StIdle;
         r_read_done  <= 1'b0;
         r_read_error <= 1'b0;
         r_read_data  <= '0;
      end else begin
         r_read_done  <= 1'b0;
         r_read_error <= 1'b0;
         unique case (r_rst)
            StIdle: if (read) begin
               r_rst        <= StAck;
               r_read_done  <= 1'b1;
               r_read_error <= w_rerr;
               r_read_data  <= w_rerr ? '0 : w_rmux;
            end
            StAck:     r_rst <= StWaitLow;
            StWaitLow: if (!read) r_rst <= StIdle;
            default:   r_rst <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_cnt <= '0;
      else       r_cnt <= r_cnt + 32'd1;
   end

`ifdef GP_REG_BANK_IRQ_EN
   logic [7:0] r_irq_prev, r_sticky, w_rise, w_clr;
   logic       r_irq;

   assign w_rise = irq_src & ~r_irq_prev;
   assign w_clr  = (w_wupd && w_widx == 4'd15 && write_strobe[0]) ? write_data[7:0] : 8'h00;

   // A new edge on the same cycle as a W1C clear leaves the bit set.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_irq_prev <= '0;
         r_sticky   <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_irq_prev <= irq_src;
         r_sticky   <= (r_sticky & ~w_clr) | w_rise;
         r_irq      <= |r_sticky;
      end
   end

   assign w_reg15 = DATA_WIDTH'({24'h0, r_sticky});
   assign irq     = r_irq;
`else
   logic [DATA_WIDTH-1:0] r_reg15;
   logic                  w_unused_irq;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_reg15 <= '0;
      end else if (w_wupd && w_widx == 4'd15) begin
         r_reg15 <= (r_reg15 & ~w_wmask) | (write_data & w_wmask);
      end
   end

   assign w_unused_irq = ^irq_src;
   assign w_reg15      = r_reg15;
   assign irq          = 1'b0;
`endif

   assign write_done  = r_write_done;
   assign write_error = r_write_error;
   assign read_done   = r_read_done;
   assign read_error  = r_read_error;
   assign read_data   = r_read_data;
   assign ctrl0       = 32'(r_regs[0]);

endmodule
